// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared state encoding and default bit timing for the rgb decoder and transmitter
package rgb_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } rgb_state_t;

    localparam int RGB_T_BIT   = 30;
    localparam int RGB_T_MAX   = 60;
    localparam int RGB_T_LATCH = 2500;

endpackage

// File: rtl/rgb_sync2.sv
// rtl/rgb_sync2.sv - two-flop input synchronizer with one-cycle rise/fall detect
module rgb_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic fall
);

    logic din_m;
    logic din_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_m <= 1'b0;
            din_s <= 1'b0;
            din_d <= 1'b0;
        end else begin
            din_m <= din;
            din_s <= din_m;
            din_d <= din_s;
        end
    end

    assign rise = din_s & ~din_d;
    assign fall = ~din_s & din_d;

endmodule

// File: rtl/rgb_decode.sv
// rtl/rgb_decode.sv - one-wire pulse-width RGB stream decoder with byte, frame-end and error strobes
module rgb_decode
    import rgb_pkg::*;
#(
    parameter int T_BIT   = RGB_T_BIT,
    parameter int T_MAX   = RGB_T_MAX,
    parameter int T_LATCH = RGB_T_LATCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic [7:0] count,
    output logic       endevent,
    output logic       err
);

    localparam int HW = $clog2(T_MAX + 1);
    localparam int LW = $clog2(T_LATCH + 1);

    localparam logic [HW-1:0] HI_ONE  = HW'(T_BIT);
    localparam logic [HW-1:0] HI_MAX  = HW'(T_MAX);
    localparam logic [HW-1:0] HI_INIT = HW'(1);
    localparam logic [LW-1:0] LO_LAT  = LW'(T_LATCH);
    localparam logic [LW-1:0] LO_LATM = LW'(T_LATCH - 1);
    localparam logic [LW-1:0] LO_INIT = LW'(1);

    logic [1:0]    rst_pipe;
    logic          rst_i;
    logic          din_s;
    logic          rise;
    logic          fall;
    rgb_state_t    state;
    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic          bit_val;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_i = rst_pipe[1];

    rgb_sync2 u_sync (
        .clk   (clk),
        .reset (rst_i),
        .din   (din),
        .din_s (din_s),
        .rise  (rise),
        .fall  (fall)
    );

    // Both counters count synchronized samples of the current level, so the
    // cycle that reveals an edge already counts as the first sample.
    assign bit_val = (high_cnt >= HI_ONE);

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_SYNC;
            high_cnt <= '0;
            low_cnt  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data     <= '0;
            valid    <= 1'b0;
            count    <= '0;
            endevent <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid    <= 1'b0;
            endevent <= 1'b0;
            err      <= 1'b0;
            if (valid) begin
                count <= count + 8'd1;
            end
            case (state)
                ST_SYNC: begin
                    if (din_s) begin
                        low_cnt <= '0;
                    end else if (low_cnt == LO_LATM) begin
                        low_cnt <= LO_LAT;
                        state   <= ST_LOW;
                    end else begin
                        low_cnt <= low_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_cnt <= HI_INIT;
                        state    <= ST_HIGH;
                    end else if (low_cnt != LO_LAT) begin
                        low_cnt <= low_cnt + 1'b1;
                        if (low_cnt == LO_LATM) begin
                            endevent <= 1'b1;
                            err      <= (bit_cnt != 3'd0);
                            count    <= '0;
                            bit_cnt  <= '0;
                            shreg    <= '0;
                        end
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        low_cnt <= LO_INIT;
                        state   <= ST_LOW;
                        if (bit_cnt == 3'd7) begin
                            data  <= {shreg, bit_val};
                            valid <= 1'b1;
                            shreg <= '0;
                        end else begin
                            shreg <= {shreg[5:0], bit_val};
                        end
                    end else if (high_cnt == HI_MAX) begin
                        // Pulse too long: drop the byte and resynchronize on a latch.
                        err     <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        low_cnt <= '0;
                        state   <= ST_SYNC;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_decode.sv
// tb/tb_rgb_decode.sv - randomized self-checking bench for rgb_decode against a pulse-width model
module tb_rgb_decode;
    import rgb_pkg::*;

    localparam int T_BIT   = RGB_T_BIT;
    localparam int T_MAX   = RGB_T_MAX;
    localparam int T_LATCH = RGB_T_LATCH;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       din   = 1'b0;
    logic [7:0] data;
    logic [7:0] count;
    logic       valid;
    logic       endevent;
    logic       err;

    int checks = 0;
    int errors = 0;

    rgb_decode #(
        .T_BIT   (T_BIT),
        .T_MAX   (T_MAX),
        .T_LATCH (T_LATCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .din      (din),
        .data     (data),
        .valid    (valid),
        .count    (count),
        .endevent (endevent),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Pulse-width model on raw din samples; the decoder sees each sample two edges late.
    bit         armed, lvl, inc_pend, d1, d2;
    int         hi_len, lo_len, nbits, rel;
    logic [7:0] sh, m_data, m_count;
    bit         m_valid, m_end, m_err;

    task automatic model_reset();
        armed = 0; lvl = 0; inc_pend = 0; d1 = 0; d2 = 0;
        hi_len = 0; lo_len = 0; nbits = 0; rel = 0;
        sh = 8'h00; m_data = 8'h00; m_count = 8'h00;
        m_valid = 0; m_end = 0; m_err = 0;
    endtask

    task automatic model_step(input bit s);
        m_valid = 0; m_end = 0; m_err = 0;
        if (inc_pend) begin
            m_count = m_count + 8'd1;
            inc_pend = 0;
        end
        if (!armed) begin
            lo_len = s ? 0 : lo_len + 1;
            if (lo_len >= T_LATCH) begin
                armed = 1; lo_len = T_LATCH; lvl = 0;
            end
        end else if (s) begin
            hi_len = lvl ? hi_len + 1 : 1;
            lvl = 1;
            if (hi_len > T_MAX) begin
                m_err = 1; armed = 0; lo_len = 0; nbits = 0; sh = 8'h00;
            end
        end else if (lvl) begin
            sh = {sh[6:0], (hi_len >= T_BIT) ? 1'b1 : 1'b0};
            nbits++; lo_len = 1; lvl = 0;
            if (nbits == 8) begin
                m_data = sh; m_valid = 1; inc_pend = 1; nbits = 0; sh = 8'h00;
            end
        end else if (lo_len < T_LATCH) begin
            lo_len++;
            if (lo_len == T_LATCH) begin
                m_end = 1; m_count = 8'h00; m_err = (nbits != 0); nbits = 0; sh = 8'h00;
            end
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            model_reset();
        end else begin
            if (rel < 3) rel++;
            if (rel >= 3) model_step(d2);
            d2 = d1;
            d1 = din;
        end
    end

    int         n_valid = 0, n_end = 0, n_err = 0, n_both = 0;
    logic [7:0] last_data = 8'h00, last_count = 8'h00;
    logic [18:0] e_vec, a_vec;

    always @(negedge clk) begin
        e_vec = reset ? {m_data, m_count, m_valid, m_end, m_err} : 19'd0;
        a_vec = {data, count, valid, endevent, err};
        checks++;
        if (a_vec !== e_vec) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got data=%h count=%0d valid=%b end=%b err=%b expected data=%h count=%0d valid=%b end=%b err=%b",
                     $time, a_vec[18:11], a_vec[10:3], a_vec[2], a_vec[1], a_vec[0],
                     e_vec[18:11], e_vec[10:3], e_vec[2], e_vec[1], e_vec[0]);
        end
        if (valid) begin
            n_valid++; last_data = data; last_count = count;
        end
        if (endevent) n_end++;
        if (err) n_err++;
        if (err && endevent) n_both++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        din = 1'b1; tick(hi);
        din = 1'b0; tick(lo);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) pulse(b[i] ? 40 : 20, 40);
    endtask

    task automatic send_rand_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--)
            pulse(b[i] ? int'($urandom_range(T_MAX, T_BIT)) : int'($urandom_range(T_BIT - 1, 1)),
                  int'($urandom_range(60, 1)));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    int v0, e0, r0, b0;

    initial begin
        #1 reset = 1'b0;
        tick(5);
        chk("reset_outputs", int'({data, count, valid, endevent, err}), 0);
        reset = 1'b1;
        tick(T_LATCH + 4);

        send_byte(8'h05); tick(5);
        chk("s1_valid", n_valid, 1);
        chk("s1_data", last_data, 8'h05);
        chk("s1_count", last_count, 0);
        chk("s1_err", n_err, 0);

        send_byte(8'h02);
        chk("s2_count1", last_count, 1);
        send_byte(8'h03);
        chk("s2_data3", last_data, 8'h03);
        chk("s2_count2", last_count, 2);
        tick(T_LATCH);
        chk("s2_valid", n_valid, 3);
        chk("s2_end", n_end, 1);
        send_byte(8'hC3);
        chk("s2_next_count", last_count, 0);
        chk("s2_next_data", last_data, 8'hC3);

        v0 = n_valid; e0 = n_end; r0 = n_err;
        pulse(40, 40); pulse(20, 40); pulse(40, 40);
        pulse(61, 40);
        chk("s3_err", n_err, r0 + 1);
        send_byte(8'hFF);
        chk("s3_no_valid", n_valid, v0);
        tick(T_LATCH + 10);
        send_byte(8'h3C);
        chk("s3_valid", n_valid, v0 + 1);
        chk("s3_data", last_data, 8'h3C);
        chk("s3_no_end", n_end, e0);

        v0 = n_valid; e0 = n_end; b0 = n_both;
        for (int i = 0; i < 5; i++) pulse(40, 40);
        tick(T_LATCH + 10);
        chk("s4_both", n_both, b0 + 1);
        chk("s4_end", n_end, e0 + 1);
        chk("s4_no_valid", n_valid, v0);
        chk("s4_data_held", data, 8'h3C);

        begin
            logic [7:0] pat;
            pat = 8'hA5;
            for (int i = 7; i >= 0; i--) pulse(pat[i] ? T_BIT : T_BIT - 1, 40);
        end
        tick(3);
        chk("s5_data", last_data, 8'hA5);
        chk("s5_count", last_count, 0);

        v0 = n_valid; e0 = n_end;
        for (int k = 0; k < 6; k++) send_rand_byte(8'($urandom));
        tick(T_LATCH + 10);
        chk("s6_valid", n_valid, v0 + 6);
        chk("s6_end", n_end, e0 + 1);

        v0 = n_valid;
        pulse(40, 40); pulse(20, 40); pulse(40, 40);
        din = 1'b1; tick(10);
        reset = 1'b0; din = 1'b0; tick(1);
        chk("s7_reset_outputs", int'({data, count, valid, endevent, err}), 0);
        tick(2);
        reset = 1'b1;
        send_byte(8'hFF);
        chk("s7_no_valid", n_valid, v0);
        tick(T_LATCH + 10);
        send_byte(8'h5A);
        chk("s7_valid", n_valid, v0 + 1);
        chk("s7_data", last_data, 8'h5A);
        chk("s7_count", last_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
